gauss_filter_arbiter: RTL and testbench
=======================================

# gauss_filter_arbiter

Round-robin scheduler that shares one Gaussian filter datapath instance between REQ_N window-producing requesters. It accepts one pixel window per cycle via valid/ready, forwards it to the filter with a requester tag, and tracks in-flight tags with a credit counter and tag FIFO. Returned filter results leave with the originating requester ID. It sits between per-stream window generators and the shared filter; the filter's result path has no backpressure.

## Interface
- PIX_DATA_W, 12, pixel width.
- WINDOW_SIZE, 7, window edge (3, 5 or 7).
- INPUTS_AMOUNT, WINDOW_SIZE**2, pixels per window.
- REQ_N, 4, number of requesters (2..16).
- MAX_INFLIGHT, 16, max windows issued but not returned. Must be ≥ filter latency for full throughput; power of two.
- ID_W, $clog2(REQ_N), requester ID width.

Reset rst_i, asynchronous, active-high; clock clk_i.
- clk_i  in  1  clock.
- rst_i  in  1  async active-high reset.
- enable_i  in  1  grant enable; low blocks new grants only.
- req_valid_i  in  REQ_N  per-requester window valid.
- req_data_i  in  REQ_N x INPUTS_AMOUNT x PIX_DATA_W  per-requester windows.
- req_ready_o  out  REQ_N  one-hot accept, combinational.
- filt_valid_o  out  1  window valid to filter (data_valid_i).
- filt_data_o  out  INPUTS_AMOUNT x PIX_DATA_W  window to filter.
- filt_valid_i  in  1  filter result valid.
- filt_data_i  in  PIX_DATA_W  filter result.
- res_valid_o  out  1  tagged result valid.
- res_id_o  out  ID_W  originating requester.
- res_data_o  out  PIX_DATA_W  filtered pixel.
- idle_o  out  1  nothing in flight and nothing being issued.
- err_o  out  1  sticky: result returned with no tag outstanding.

## Operation
- Grant (combinational): if enable_i=1 and inflight < MAX_INFLIGHT, select the first i with req_valid_i[i]=1, scanning ptr, ptr+1, … mod REQ_N. req_ready_o[i]=1 for that i only; otherwise req_ready_o=0. req_ready_o may depend on req_valid_i.
- Transfer when req_valid_i[k] & req_ready_o[k]. Requesters hold valid and data stable until transfer.
- On a transfer to k: ptr <= (k+1) mod REQ_N; tag k is pushed into the tag FIFO; inflight increments. With no transfer, ptr holds.
- Return: filt_valid_i=1 with inflight>0 pops the tag FIFO head and decrements inflight. Push and pop in the same cycle leave inflight unchanged and are legal at any occupancy, including empty-with-push and full-with-pop.
- Issue at inflight==MAX_INFLIGHT is forbidden, even if a return occurs in the same cycle. The FIFO therefore never overflows.
- Spurious return: filt_valid_i=1 with inflight==0 sets err_o=1, which holds until reset. No pop, no decrement, no res_valid_o.
- Results stay in issue order because filter latency is fixed.
- enable_i low: no new grants; in-flight results still drain normally.
- idle_o = (inflight==0) & !filt_valid_o.

## Timing
- Reset values: filt_valid_o=0, filt_data_o=0, res_valid_o=0, res_id_o=0, res_data_o=0, err_o=0, idle_o=1, ptr=0, inflight=0, FIFO empty. req_ready_o is 0 while rst_i is high.
- Issue path is registered. A transfer in cycle t gives filt_valid_o=1 and filt_data_o=req_data_i[k] in t+1. filt_valid_o is 0 in cycles with no transfer.
- Return path is registered. filt_valid_i in cycle t gives res_valid_o, res_data_o=filt_data_i and res_id_o=FIFO head in t+1.
- Throughput: one window per cycle, sustained while inflight < MAX_INFLIGHT.
- Reset mid-operation clears all state. The filter shares rst_i, so in-flight windows are dropped and no stale results appear afterwards.

## Test plan
- Single request: req 0 sends a window of all pixels = 100 with real 7x7 filter → req_ready_o=0001 in the same cycle, filt_valid_o next cycle, later exactly one res_valid_o with res_id_o=0, res_data_o=100.
- Fairness: all 4 requesters valid continuously → grants 0,1,2,3,0,1,… one per cycle; res_id_o sequence identical; no bubbles.
- Pointer: only req 2 valid and accepted, then reqs 1 and 3 valid → grant order 3 then 1.
- Credits: MAX_INFLIGHT=4, filter stub returns after 20 cycles → 4 issues, then req_ready_o=0. Each return allows exactly one new grant in the following cycle. A same-cycle push and pop at inflight=3 keeps inflight=3.
- enable_i dropped after 3 issues → no further req_ready_o; 3 results delivered in order; idle_o=1 one cycle after the last return.
- Spurious filt_valid_i with inflight=0 → err_o=1 and stays 1, res_valid_o=0. Reset clears err_o.

Source files
------------

// File: rtl/gauss_filter_arbiter.sv
// gauss_filter_arbiter: round-robin sharing of one Gaussian filter among REQ_N window streams,
// with a credit counter and tag FIFO so each result returns with its originating requester ID.
module gauss_filter_arbiter #(
    parameter int PIX_DATA_W    = 12,
    parameter int WINDOW_SIZE   = 7,
    parameter int INPUTS_AMOUNT = WINDOW_SIZE**2,
    parameter int REQ_N         = 4,
    parameter int MAX_INFLIGHT  = 16,
    parameter int ID_W          = $clog2(REQ_N)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     enable_i,
    input  logic [REQ_N-1:0]                         req_valid_i,
    input  logic [REQ_N*INPUTS_AMOUNT*PIX_DATA_W-1:0] req_data_i,
    output logic [REQ_N-1:0]                         req_ready_o,
    output logic                                     filt_valid_o,
    output logic [INPUTS_AMOUNT*PIX_DATA_W-1:0]      filt_data_o,
    input  logic                                     filt_valid_i,
    input  logic [PIX_DATA_W-1:0]                    filt_data_i,
    output logic                                     res_valid_o,
    output logic [ID_W-1:0]                          res_id_o,
    output logic [PIX_DATA_W-1:0]                    res_data_o,
    output logic                                     idle_o,
    output logic                                     err_o
);
    localparam int WIN_W = INPUTS_AMOUNT*PIX_DATA_W;
    localparam int AW    = $clog2(MAX_INFLIGHT);
    localparam int CW    = AW + 1;

    logic [ID_W-1:0]       r_ptr;
    logic [CW-1:0]         r_inflight;
    logic [AW-1:0]         r_wr, r_rd;
    logic [ID_W-1:0]       r_tags [MAX_INFLIGHT];
    logic                  r_filt_valid, r_res_valid, r_err;
    logic [WIN_W-1:0]      r_filt_data;
    logic [ID_W-1:0]       r_res_id;
    logic [PIX_DATA_W-1:0] r_res_data;

    logic                  w_open, w_found, w_push, w_pop;
    logic [2*REQ_N-1:0]    w_dbl;
    logic [REQ_N-1:0]      w_rot;
    logic [ID_W-1:0]       w_off, w_gnt, w_nxt;
    logic [ID_W:0]         w_sum;
    logic [WIN_W-1:0]      w_win;

    // Rotate valids so bit j is requester (ptr+j) mod REQ_N, then take the lowest set bit.
    always_comb begin
        w_open = enable_i && !rst_i && (r_inflight < CW'(MAX_INFLIGHT));
        w_dbl  = {req_valid_i, req_valid_i} >> r_ptr;
        w_rot  = w_dbl[REQ_N-1:0];
        w_found = |w_rot;
        w_off = '0;
        for (int j = REQ_N-1; j >= 0; j--)
            if (w_rot[j]) w_off = ID_W'(j);
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        w_gnt = (w_sum >= (ID_W+1)'(REQ_N)) ? ID_W'(w_sum - (ID_W+1)'(REQ_N)) : w_sum[ID_W-1:0];
        w_nxt = (w_gnt == ID_W'(REQ_N-1)) ? '0 : w_gnt + 1'b1;
        w_win = '0;
        for (int j = 0; j < REQ_N; j++)
            if (ID_W'(j) == w_gnt) w_win = req_data_i[j*WIN_W +: WIN_W];
        w_push = w_open && w_found;
        w_pop  = filt_valid_i && (r_inflight != '0);
        req_ready_o = w_push ? (REQ_N'(1) << w_gnt) : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr        <= '0;
            r_inflight   <= '0;
            r_wr         <= '0;
            r_rd         <= '0;
            r_filt_valid <= 1'b0;
            r_filt_data  <= '0;
            r_res_valid  <= 1'b0;
            r_res_id     <= '0;
            r_res_data   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_filt_valid <= w_push;
            r_res_valid  <= w_pop;
            r_inflight   <= r_inflight + CW'(w_push) - CW'(w_pop);
            if (w_push) begin
                r_filt_data <= w_win;
                r_ptr       <= w_nxt;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd       <= r_rd + 1'b1;
                r_res_id   <= r_tags[r_rd];
                r_res_data <= filt_data_i;
            end
            // A result with nothing outstanding means the filter and arbiter disagree.
            if (filt_valid_i && r_inflight == '0) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_tags[r_wr] <= w_gnt;
    end

    assign filt_valid_o = r_filt_valid;
    assign filt_data_o  = r_filt_data;
    assign res_valid_o  = r_res_valid;
    assign res_id_o     = r_res_id;
    assign res_data_o   = r_res_data;
    assign err_o        = r_err;
    assign idle_o       = (r_inflight == '0) && !r_filt_valid;
endmodule

// File: tb/tb_gauss_filter_arbiter.sv
// tb_gauss_filter_arbiter: directed vectors against a fixed-latency filter stub that
// returns the window's centre pixel; a scoreboard checks result IDs and data in issue order.
module tb_gauss_filter_arbiter;
    localparam int PW = 12;
    localparam int NP = 49;
    localparam int RN = 4;
    localparam int WIN_W = PW*NP;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic enable = 1'b0;
    logic [RN-1:0] req_valid = '0;
    logic [RN*WIN_W-1:0] req_data;
    logic [RN-1:0] req_ready_o;
    logic filt_valid_o;
    logic [WIN_W-1:0] filt_data_o;
    logic filt_valid_i;
    logic [PW-1:0] filt_data_i;
    logic res_valid_o;
    logic [1:0] res_id_o;
    logic [PW-1:0] res_data_o;
    logic idle_o, err_o;

    logic [31:0] vp;
    logic [PW-1:0] dp [32];
    logic [4:0] lat_m1 = 5'd1;
    logic spur = 1'b0;

    int checks = 0;
    int errors = 0;
    int nres = 0;
    int exp_q[$];

    typedef struct {
        logic           rst;
        logic [RN-1:0]  v;
        logic           en;
        logic [RN-1:0]  er;
    } vec_t;
    vec_t tbl[$];

    gauss_filter_arbiter #(.PIX_DATA_W(PW), .WINDOW_SIZE(7), .REQ_N(RN), .MAX_INFLIGHT(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready_o),
        .filt_valid_o(filt_valid_o), .filt_data_o(filt_data_o),
        .filt_valid_i(filt_valid_i), .filt_data_i(filt_data_i),
        .res_valid_o(res_valid_o), .res_id_o(res_id_o), .res_data_o(res_data_o),
        .idle_o(idle_o), .err_o(err_o));

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pix(int k, int p);
        return PW'(100*(k+1) + p*k);
    endfunction

    function automatic logic [WIN_W-1:0] win(int k);
        logic [WIN_W-1:0] w;
        for (int p = 0; p < NP; p++) w[p*PW +: PW] = pix(k, p);
        return w;
    endfunction

    initial for (int k = 0; k < RN; k++) req_data[k*WIN_W +: WIN_W] = win(k);

    // Filter stub: shares the reset, returns the centre pixel after a fixed latency.
    always @(posedge clk or posedge rst_i) begin
        if (rst_i) vp <= '0;
        else begin
            vp <= {vp[30:0], filt_valid_o};
            dp[0] <= filt_data_o[24*PW +: PW];
            for (int i = 1; i < 32; i++) dp[i] <= dp[i-1];
        end
    end
    assign filt_valid_i = vp[lat_m1] | spur;
    assign filt_data_i  = dp[lat_m1];

    task automatic chk(input string n, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (res_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got id %0d data %0d, required no result", res_id_o, res_data_o);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("res_id", {586'd0, res_id_o}, WIN_W'(e));
                chk("res_data", {576'd0, res_data_o}, {576'd0, pix(e, 24)});
                nres++;
            end
        end
    end

    task automatic step(input logic [RN-1:0] v, input logic en, input logic [RN-1:0] er);
        int id;
        req_valid = v;
        enable = en;
        #1;
        chk("req_ready", {584'd0, req_ready_o}, {584'd0, er});
        @(posedge clk);
        #1;
        chk("filt_valid", {587'd0, filt_valid_o}, {587'd0, |er});
        if (er != '0) begin
            id = 0;
            for (int i = 0; i < RN; i++) if (er[i]) id = i;
            chk("filt_data", filt_data_o, win(id));
            exp_q.push_back(id);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req_valid = '1;
        enable = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_ready", {584'd0, req_ready_o}, '0);
        @(posedge clk);
        #1;
        chk("rst_filt_valid", {587'd0, filt_valid_o}, '0);
        chk("rst_filt_data", filt_data_o, '0);
        chk("rst_res_valid", {587'd0, res_valid_o}, '0);
        chk("rst_res_id", {586'd0, res_id_o}, '0);
        chk("rst_res_data", {576'd0, res_data_o}, '0);
        chk("rst_err", {587'd0, err_o}, '0);
        chk("rst_idle", {587'd0, idle_o}, WIN_W'(1));
        rst_i = 1'b0;
        req_valid = '0;
    endtask

    task automatic add(input logic r, input logic [RN-1:0] v, input logic en, input logic [RN-1:0] er);
        tbl.push_back('{rst: r, v: v, en: en, er: er});
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add(1'b0, 4'b0000, 1'b1, 4'b0000);
    endtask

    initial begin
        int base;
        // single request from requester 0
        add(1'b1, 4'b0001, 1'b1, 4'b0001);
        add_idle(5);
        // fairness: all valid, grants rotate with no bubbles
        for (int i = 0; i < 8; i++) add(i == 0, 4'b1111, 1'b1, 4'(1 << (i % 4)));
        add_idle(5);
        // pointer: after granting 2, scan starts at 3
        add(1'b1, 4'b0100, 1'b1, 4'b0100);
        add(1'b0, 4'b1010, 1'b1, 4'b1000);
        add(1'b0, 4'b0010, 1'b1, 4'b0010);
        add_idle(5);

        lat_m1 = 5'd1;
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].v, tbl[i].en, tbl[i].er);
        end
        chk("table_results", WIN_W'(nres), WIN_W'(12));

        // enable dropped after 3 issues; idle one cycle after the last return
        do_reset();
        base = nres;
        step(4'b1111, 1'b1, 4'b0001);
        step(4'b1111, 1'b1, 4'b0010);
        step(4'b1111, 1'b1, 4'b0100);
        step(4'b1111, 1'b0, 4'b0000);
        chk("en_idle_a", {587'd0, idle_o}, '0);
        step(4'b1111, 1'b0, 4'b0000);
        chk("en_idle_b", {587'd0, idle_o}, '0);
        step(4'b1111, 1'b0, 4'b0000);
        chk("en_idle_c", {587'd0, idle_o}, WIN_W'(1));
        step(4'b1111, 1'b0, 4'b0000);
        chk("en_results", WIN_W'(nres - base), WIN_W'(3));

        // credits: 4 in flight, long filter latency
        do_reset();
        lat_m1 = 5'd19;
        base = nres;
        for (int c = 0; c < 46; c++)
            step(4'b0001, 1'b1, ((c < 4) || (c >= 22 && c < 26) || c >= 44) ? 4'b0001 : 4'b0000);
        for (int c = 0; c < 25; c++) step(4'b0000, 1'b1, 4'b0000);
        chk("credit_results", WIN_W'(nres - base), WIN_W'(10));
        chk("credit_idle", {587'd0, idle_o}, WIN_W'(1));

        // spurious return sets a sticky error
        do_reset();
        lat_m1 = 5'd1;
        spur = 1'b1;
        step(4'b0000, 1'b1, 4'b0000);
        spur = 1'b0;
        chk("spur_err", {587'd0, err_o}, WIN_W'(1));
        chk("spur_res_valid", {587'd0, res_valid_o}, '0);
        step(4'b0001, 1'b1, 4'b0001);
        for (int c = 0; c < 5; c++) step(4'b0000, 1'b1, 4'b0000);
        chk("spur_err_sticky", {587'd0, err_o}, WIN_W'(1));

        // reset with windows in flight drops them
        do_reset();
        step(4'b1111, 1'b1, 4'b0001);
        step(4'b1111, 1'b1, 4'b0010);
        base = nres;
        do_reset();
        for (int c = 0; c < 6; c++) step(4'b0000, 1'b1, 4'b0000);
        chk("midrst_no_results", WIN_W'(nres - base), '0);
        chk("final_queue_empty", WIN_W'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
